dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-ported
// 16-bit data memory. Port 0 is the CPU data port, port 1 the loader/debug
// port. Each granted transaction occupies one GRANT cycle on the memory bus
// and is completed by a one-cycle ack pulse on the owning port.
module dmem_arbiter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        mem_read,
  output logic        mem_write_en,
  output logic [15:0] mem_access_addr,
  output logic [15:0] mem_write_data,
  input  logic [15:0] mem_read_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        last_grant_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        ack0_q;
  logic        ack1_q;
  logic [15:0] rdata0_q;
  logic [15:0] rdata1_q;
  logic        mem_read_q;
  logic        mem_write_en_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic        busy_q;

  // Selection signals (combinational, consumed only in IDLE)
  logic        elig0_s;
  logic        elig1_s;
  logic        sel_valid_s;
  logic        sel_port_s;
  logic        sel_we_s;
  logic [15:0] sel_addr_s;
  logic [15:0] sel_wdata_s;

  // Eligibility, round-robin choice and next state; a port in its own ack
  // cycle is not eligible, which also enforces the 3-cycle per-port spacing.
  always_comb begin
    elig0_s     = req0 & ~ack0_q;
    elig1_s     = req1 & ~ack1_q;
    sel_valid_s = 1'b0;
    sel_port_s  = 1'b0;
    state_d     = state_q;
    case (state_q)
      ST_IDLE: begin
        if (elig0_s && elig1_s) begin
          sel_valid_s = 1'b1;
          sel_port_s  = ~last_grant_q;
        end else if (elig0_s) begin
          sel_valid_s = 1'b1;
          sel_port_s  = 1'b0;
        end else if (elig1_s) begin
          sel_valid_s = 1'b1;
          sel_port_s  = 1'b1;
        end else begin
          sel_valid_s = 1'b0;
          sel_port_s  = 1'b0;
        end
        if (sel_valid_s) begin
          state_d = sel_port_s ? ST_GRANT1 : ST_GRANT0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT0: state_d = ST_IDLE;
      ST_GRANT1: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    sel_we_s    = sel_port_s ? we1    : we0;
    sel_addr_s  = sel_port_s ? addr1  : addr0;
    sel_wdata_s = sel_port_s ? wdata1 : wdata0;
  end

  // Arbiter FSM with registered memory-side and requester-side outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= 1'b1;
      we_q           <= 1'b0;
      addr_q         <= 16'h0000;
      wdata_q        <= 16'h0000;
      ack0_q         <= 1'b0;
      ack1_q         <= 1'b0;
      rdata0_q       <= 16'h0000;
      rdata1_q       <= 16'h0000;
      mem_read_q     <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_addr_q     <= 16'h0000;
      mem_wdata_q    <= 16'h0000;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ack0_q         <= 1'b0;
      ack1_q         <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_addr_q     <= 16'h0000;
      mem_wdata_q    <= 16'h0000;
      busy_q         <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sel_valid_s) begin
            we_q           <= sel_we_s;
            addr_q         <= sel_addr_s;
            wdata_q        <= sel_wdata_s;
            last_grant_q   <= sel_port_s;
            mem_read_q     <= ~sel_we_s;
            mem_write_en_q <= sel_we_s;
            mem_addr_q     <= sel_addr_s;
            mem_wdata_q    <= sel_wdata_s;
            busy_q         <= 1'b1;
          end
        end
        ST_GRANT0: begin
          ack0_q <= 1'b1;
          if (!we_q) begin
            rdata0_q <= mem_read_data;
          end
        end
        ST_GRANT1: begin
          ack1_q <= 1'b1;
          if (!we_q) begin
            rdata1_q <= mem_read_data;
          end
        end
        default: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
        end
      endcase
    end
  end

  assign ack0            = ack0_q;
  assign ack1            = ack1_q;
  assign rdata0          = rdata0_q;
  assign rdata1          = rdata1_q;
  assign mem_read        = mem_read_q;
  assign mem_write_en    = mem_write_en_q;
  assign mem_access_addr = mem_addr_q;
  assign mem_write_data  = mem_wdata_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset_n;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic        mem_read, mem_write_en;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        busy;

  dmem_arbiter dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req0           (req0),
    .req1           (req1),
    .we0            (we0),
    .we1            (we1),
    .addr0          (addr0),
    .addr1          (addr1),
    .wdata0         (wdata0),
    .wdata1         (wdata1),
    .ack0           (ack0),
    .ack1           (ack1),
    .rdata0         (rdata0),
    .rdata1         (rdata1),
    .mem_read       (mem_read),
    .mem_write_en   (mem_write_en),
    .mem_access_addr(mem_access_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory attached to the arbiter (low address byte selects the word)
  logic [15:0] tb_mem [256];
  assign mem_read_data = tb_mem[mem_access_addr[7:0]];

  // Memory write port
  always @(posedge clock) begin
    if (mem_write_en) tb_mem[mem_access_addr[7:0]] <= mem_write_data;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: which port (if any) owns the memory this cycle, the
  // transaction it captured, who is being acked, and the expected results.
  int          m_owner;      // -1 none, else port in its grant cycle
  int          m_acked;      // -1 none, else port acked this cycle
  int          m_last;
  logic        t_we;
  logic [15:0] t_addr, t_wdata;
  logic [15:0] m_rdata [2];
  logic [15:0] m_mem [256];

  function automatic void model_reset();
    m_owner = -1; m_acked = -1; m_last = 1;
    t_we = 1'b0; t_addr = 16'h0000; t_wdata = 16'h0000;
    m_rdata[0] = 16'h0000; m_rdata[1] = 16'h0000;
  endfunction

  // Advance the reference across one clock edge using the current inputs.
  function automatic void model_step();
    bit want0, want1;
    int pick;
    if (m_owner >= 0) begin
      // transaction completes: ack its owner, apply its effect
      if (t_we) m_mem[t_addr[7:0]] = t_wdata;
      else      m_rdata[m_owner] = m_mem[t_addr[7:0]];
      m_acked = m_owner;
      m_owner = -1;
    end else begin
      want0 = req0 && (m_acked != 0);
      want1 = req1 && (m_acked != 1);
      if (want0 && want1) pick = (m_last == 0) ? 1 : 0;
      else if (want0)     pick = 0;
      else if (want1)     pick = 1;
      else                pick = -1;
      m_acked = -1;
      if (pick >= 0) begin
        m_owner = pick;
        m_last  = pick;
        t_we    = (pick == 1) ? we1 : we0;
        t_addr  = (pick == 1) ? addr1 : addr0;
        t_wdata = (pick == 1) ? wdata1 : wdata0;
      end
    end
  endfunction

  task automatic check_outputs();
    bit g;
    g = (m_owner >= 0);
    check_val("ack0", {15'd0, ack0}, {15'd0, m_acked == 0});
    check_val("ack1", {15'd0, ack1}, {15'd0, m_acked == 1});
    check_val("rdata0", rdata0, m_rdata[0]);
    check_val("rdata1", rdata1, m_rdata[1]);
    check_val("mem_read", {15'd0, mem_read}, {15'd0, g && !t_we});
    check_val("mem_write_en", {15'd0, mem_write_en}, {15'd0, g && t_we});
    check_val("mem_addr", mem_access_addr, g ? t_addr : 16'h0000);
    check_val("mem_wdata", mem_write_data, g ? t_wdata : 16'h0000);
    check_val("busy", {15'd0, busy}, {15'd0, g});
    check_val("ack_excl", {15'd0, ack0 & ack1}, 16'h0000);
    check_val("rw_excl", {15'd0, mem_read & mem_write_en}, 16'h0000);
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  int ack_order[$];

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      tb_mem[i] = v;
      m_mem[i]  = v;
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    reset_n = 1'b0;
    model_reset();
    #12;
    check_outputs();
    reset_n = 1'b1;

    // Single write from port 0
    drive(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    check_val("wr_en", {15'd0, mem_write_en}, 16'h0001);
    check_val("wr_addr", mem_access_addr, 16'h0010);
    check_val("wr_data", mem_write_data, 16'hBEEF);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    check_val("wr_ack0", {15'd0, ack0}, 16'h0001);
    check_val("wr_rdata0", rdata0, 16'h0000);
    step();

    // Single read from port 1 of the word just written
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000);
    step();
    check_val("rd_en", {15'd0, mem_read}, 16'h0001);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    check_val("rd_ack1", {15'd0, ack1}, 16'h0001);
    check_val("rd_ack0", {15'd0, ack0}, 16'h0000);
    check_val("rd_rdata1", rdata1, 16'hBEEF);
    step();

    // Tie straight after reset: port 0 first, then strict alternation
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000);
    for (int i = 0; i < 9; i++) begin
      step();
      if (ack0) ack_order.push_back(0);
      if (ack1) ack_order.push_back(1);
    end
    check_val("tie_count", 16'(ack_order.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_order.size()) check_val("tie_order", 16'(ack_order[i]), 16'(i % 2));
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(); step(); step();

    // Address change during GRANT0 is ignored
    drive(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    drive(1'b0, 1'b0, 16'h0008, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #2;
    check_val("hold_addr", mem_access_addr, 16'h0004);
    step();
    step();

    // Request withdrawal: req1 pulses for one cycle during GRANT0
    drive(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0050, 16'h1234);
    step();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("wd_ack1", {15'd0, ack1}, 16'h0000);
      check_val("wd_wr", {15'd0, mem_write_en}, 16'h0000);
    end

    // Reset during a port-1 write aborts it
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0060, 16'hCAFE);
    step();
    check_val("rst_pre_we", {15'd0, mem_write_en}, 16'h0001);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_we", {15'd0, mem_write_en}, 16'h0000);
    check_val("rst_busy", {15'd0, busy}, 16'h0000);
    model_reset();
    check_outputs();
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("rst_ack1", {15'd0, ack1}, 16'h0000);
      check_val("rst_rdata0", rdata0, 16'h0000);
      check_val("rst_rdata1", rdata1, 16'h0000);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 1'($urandom), {8'($urandom % 2), 8'($urandom)}, 16'($urandom),
            ($urandom % 3) != 0, 1'($urandom), {8'($urandom % 2), 8'($urandom)}, 16'($urandom));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
